// File: rtl/uart_tx_drain.sv
// uart_tx_drain
// Fetches 16-bit words from an upstream FIFO and sends each one as two UART
// bytes, low byte first. Each byte is a start bit, 8 data bits LSB first,
// an optional even parity bit, and a stop bit.
// Build option: define UART_TX_PARITY_EN to insert the parity bit
// (11-bit frames). Without it, frames are 10 bits.
//
// state  | meaning
// IDLE   | line idle; waits for txEnable with a non-empty FIFO
// REQ    | single-cycle FIFO read strobe
// LATCH  | capture FIFO read data into the word register
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity over the 8 data bits (UART_TX_PARITY_EN only)
// STOP   | stop bit (1); the stop bit of byte 1 completes the word
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        txEnable,
  input  logic        fifoEmpty,
  input  logic [15:0] fifoData,
  output logic        fifoReadEn,
  output logic        tx,
  output logic        busy,
  output logic        wordDone
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             byte_q, byte_d;
  logic [15:0]      word_q, word_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic       bit_end;
  logic       fetch_ok;
  logic [7:0] cur_byte;
  logic       tx_c;

  assign bit_end  = (cnt_q == '0);
  assign fetch_ok = txEnable && !fifoEmpty;
  assign cur_byte = byte_q ? word_q[15:8] : word_q[7:0];

  // Next-state logic: bit timing is a down-counter reloaded at every bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    done_d  = 1'b0;
    // ready_q blocks a fetch on the first edge after reset release.
    ready_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (ready_q && fetch_ok) state_d = REQ;
      end
      REQ: begin
        state_d = LATCH;
      end
      LATCH: begin
        word_d  = fifoData;
        byte_d  = 1'b0;
        cnt_d   = CNT_LAST;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = CNT_LAST;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = CNT_LAST;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = CNT_LAST;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = CNT_LAST;
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = START;
          end else begin
            // Word complete. The IDLE fetch decision is taken on this same
            // edge so back-to-back words are separated only by REQ and LATCH.
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = fetch_ok ? REQ : IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial line value for the current state; high whenever no frame bit is on the line.
  always_comb begin
    tx_c = 1'b1;
    case (state_q)
      START:  tx_c = 1'b0;
      DATA:   tx_c = cur_byte[bit_q];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_c = ^cur_byte;
`endif
      default: tx_c = 1'b1;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      word_q  <= 16'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign tx         = tx_c;
  assign busy       = (state_q != IDLE);
  assign fifoReadEn = (state_q == REQ);
  assign wordDone   = done_q;

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, which sets the clock cycles per UART bit; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port txEnable, input, 1 bit: permits a new word to be fetched while high.
REQ-005 The block SHALL have port fifoEmpty, input, 1 bit: upstream FIFO empty flag.
REQ-006 The block SHALL have port fifoData, input, 16 bits: upstream FIFO read data, valid the cycle after a read strobe.
REQ-007 The block SHALL have port fifoReadEn, output, 1 bit: single-cycle read strobe to the upstream FIFO.
REQ-008 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port wordDone, output, 1 bit: one-cycle pulse when a full 16-bit word has been sent.

Function
REQ-011 The block SHALL implement these states: IDLE, REQ, LATCH, START, DATA, PARITY, STOP.
REQ-012 In IDLE, when txEnable=1 and fifoEmpty=0 at a clock edge, the state SHALL move to REQ.
REQ-013 fifoReadEn SHALL be 1 only in REQ, so each word produces exactly one strobe one cycle wide; REQ SHALL always be followed by LATCH.
REQ-014 In LATCH, fifoData SHALL be captured into a 16-bit word register, the byte index SHALL be set to 0, and the state SHALL move to START.
REQ-015 Each frame SHALL be: start bit 0, then 8 data bits LSB first, then an optional parity bit (see REQ-024), then stop bit 1.
REQ-016 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that restarts at every bit boundary.
REQ-017 Byte 0 SHALL be word[7:0] and byte 1 SHALL be word[15:8].
REQ-018 The stop bit of byte 0 SHALL be followed directly by the start bit of byte 1, with no idle cycles between them.
REQ-019 At the end of byte 1's stop bit, wordDone SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-020 A new fetch from IDLE SHALL be possible on the following edge, giving 2 idle-high cycles (REQ and LATCH) between words.
REQ-021 If txEnable falls mid-word, the current word SHALL complete; only new fetches are blocked.
REQ-022 fifoEmpty and fifoData SHALL be ignored outside IDLE and LATCH respectively.
REQ-023 tx SHALL be 1 in IDLE, REQ and LATCH.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, a PARITY state SHALL follow DATA and send even parity (XOR of the 8 data bits), giving an 11-bit frame; when undefined, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP, giving a 10-bit frame.

Reset
REQ-025 While rst=0, the block SHALL immediately (asynchronously) force state=IDLE, tx=1, busy=0, fifoReadEn=0, wordDone=0, with counters and the word register at 0.
REQ-026 Reset mid-frame SHALL abort the word with no completion pulse, and the aborted word SHALL NOT be re-fetched.
REQ-027 After rst rises, the first fetch SHALL occur no earlier than the second rising edge.

Verification
REQ-028 CLKS_PER_BIT=4, no parity, FIFO holds 0xA55A, txEnable=1 -> one fifoReadEn pulse; tx = 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; wordDone pulses once, 80 cycles after START begins.
REQ-029 Two words 0x0001 and 0x8000 queued -> exactly two strobes; tx idle-high for exactly 2 cycles between the words; wordDone pulses twice.
REQ-030 fifoEmpty=1, txEnable=1 for 100 cycles -> fifoReadEn=0, tx=1, busy=0 throughout.
REQ-031 txEnable dropped during byte 0 of 0x1234 -> both bytes 0x34 and 0x12 complete; no further strobe while the FIFO remains non-empty.
REQ-032 rst=0 asserted mid-way through the DATA bits of byte 1 -> tx=1 and busy=0 within the same cycle, no wordDone; after release, the next queued word is sent intact.
REQ-033 UART_TX_PARITY_EN defined, word 0x0703 -> byte 0x03 has parity bit 0 and byte 0x07 has parity bit 1; frames are 11 bits, 88 cycles total at CLKS_PER_BIT=4.
